// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU
// One quotient bit per cycle; signs are stripped on entry and re-applied in FIX.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              flag_q, flag_d;

    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [WIDTH:0]    trial;
    logic              ge;

    // Magnitudes of the operands; unsigned mode passes them through untouched
    assign abs_a = (is_signed && dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign abs_b = (is_signed && divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    // Partial remainder shifted left with the next dividend bit, WIDTH+1 wide
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign ge    = (trial >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        flag_d  = flag_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CALC;
                    count_d = '0;
                    quo_d   = abs_a;
                    rem_d   = '0;
                    dvs_d   = abs_b;
                    qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = is_signed & dividend[WIDTH-1];
                    zero_d  = (divisor == '0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // The remainder stays below the divisor, so WIDTH bits hold the difference
                quo_d   = {quo_q[WIDTH-2:0], ge};
                rem_d   = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                q_d     = qneg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                r_d     = rneg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                flag_d  = zero_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            flag_q  <= flag_d;
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = flag_q;

endmodule
